uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of i_rxpulse ticks per bit period; legal range 8..64.
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of the i_rxd synchronizer; legal range 2..4.
REQ-003 i_clk  input  1  clock, all logic on rising edge.
REQ-004 w_intrst  input  1  reset w_intrst, asynchronous, active-high; clock i_clk.
REQ-005 i_rxd  input  1  asynchronous serial line, idle high.
REQ-006 i_rxpulse  input  1  oversample tick, one i_clk wide, OVERSAMPLE ticks per bit.
REQ-007 o_data  output  8  received byte, stable while o_valid=1.
REQ-008 o_valid  output  1  byte available.
REQ-009 i_ready  input  1  consumer accepts; transfer when o_valid & i_ready.
REQ-010 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 o_overrun  output  1  one-cycle pulse, completed byte dropped.

Function
REQ-012 Frame: 1 start bit (0), 8 data bits MSB first, 1 stop bit (1); matches the team's uart_tx bit order.
REQ-013 i_rxd passes through SYNC_STAGES flops before any use; all decisions use the synchronized value rxs.
REQ-014 States: S_IDLE, S_START, S_DATA, S_STOP, S_BREAK; unused encodings go to S_IDLE.
REQ-015 S_IDLE: on an i_rxpulse tick with rxs=0, clear the tick counter and go to S_START.
REQ-016 Tick counter counts i_rxpulse ticks within a bit, 0..OVERSAMPLE-1, wraps to 0 at bit end; width ceil(log2(OVERSAMPLE)).
REQ-017 Bit value = majority of rxs sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, and OVERSAMPLE/2+1.
REQ-018 S_START: majority 1 (false start) -> S_IDLE, no outputs; majority 0 -> S_DATA at bit end with bit count 7.
REQ-019 S_DATA: each bit's majority shifts into the shift register LSB (MSB arrives first); after bit count 0 -> S_STOP.
REQ-020 S_STOP: decision at tick OVERSAMPLE/2+1; stop=1 -> deliver byte, go to S_IDLE immediately (no wait for bit end).
REQ-021 Stop=0 -> pulse o_frame_err, discard byte, go to S_BREAK; S_BREAK -> S_IDLE on first tick with rxs=1.
REQ-022 Delivery: o_data loads, o_valid=1 on the cycle after the stop decision (latency 1 i_clk).
REQ-023 Output buffer is 1 deep; o_valid holds, o_data unchanged until o_valid & i_ready, then o_valid=0 next cycle.
REQ-024 Delivery while o_valid=1 and i_ready=0: new byte dropped, old byte kept, o_overrun pulses one cycle.
REQ-025 Delivery in the same cycle as an accepting handshake: new byte loads, o_valid stays 1, no o_overrun.
REQ-026 i_rxpulse=0 freezes the tick counter and FSM; i_ready is honoured regardless of ticks.
REQ-027 o_frame_err and o_overrun are never both asserted in the same cycle.

Reset
REQ-028 w_intrst=1: state S_IDLE, counters 0, shift register 0, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
REQ-029 Synchronizer flops reset to 1 so reset release never produces a false start.
REQ-030 Reset mid-frame abandons the frame; no partial byte, no error pulse after release.

Structure
REQ-031 Shared package uart_pkg holds the data width (8), state encodings, and default OVERSAMPLE, shared with uart_tx.
REQ-032 One sub-module, uart_sync: parameterized SYNC_STAGES synchronizer with reset value 1.

Verification
REQ-033 OVERSAMPLE=16, send 0xA5 with clean framing -> o_data=0xA5, o_valid=1 one cycle after mid-stop, o_frame_err=0.
REQ-034 Low glitch on i_rxd of 4 ticks in idle -> false start, return to S_IDLE, no o_valid, no error.
REQ-035 Send 0x3C with stop bit forced 0, then line high -> one o_frame_err pulse, o_valid stays 0, next byte 0x81 received correctly.
REQ-036 i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_overrun pulses once at the 0x22 stop; raise i_ready -> 0x11 transferred.
REQ-037 i_ready asserted exactly on the delivery cycle of the second byte -> first byte transferred, second loaded, no o_overrun.
REQ-038 Assert w_intrst during data bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver state encodings, default oversampling.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, MSB first) with a 1-deep valid/ready output buffer.
// state   | meaning
// S_IDLE  | wait for low line on a tick;  S_START | verify start bit at mid-bit
// S_DATA  | shift 8 majority-voted bits;  S_STOP  | check stop bit, deliver or flag
// S_BREAK | line held low after a framing error, wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              w_intrst,
  input  logic              i_rxd,
  input  logic              i_rxpulse,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] T_MID_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] T_MID    = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] T_MID_P1 = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] T_END    = CW'(OVERSAMPLE - 1);

  logic              rxs;
  rx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              v0, v0_nxt, v1, v1_nxt;
  logic              maj, deliver, ferr;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (i_clk),
    .rst (w_intrst),
    .d   (i_rxd),
    .q   (rxs)
  );

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      shreg <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bcnt  <= bcnt_nxt;
      shreg <= shreg_nxt;
      v0    <= v0_nxt;
      v1    <= v1_nxt;
    end
  end

  // Two mid-bit samples are held; the third is the live rxs at tick OVERSAMPLE/2+1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    v0_nxt    = v0;
    v1_nxt    = v1;
    deliver   = 1'b0;
    ferr      = 1'b0;
    maj       = maj3(v0, v1, rxs);
    if (i_rxpulse) begin
      cnt_nxt = (cnt == T_END) ? '0 : cnt + 1'b1;
      if (cnt == T_MID_M1) v0_nxt = rxs;
      if (cnt == T_MID)    v1_nxt = rxs;
      case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (!rxs) state_nxt = S_START;
        end
        S_START: begin
          if (cnt == T_MID_P1 && maj) begin
            state_nxt = S_IDLE;
          end else if (cnt == T_END) begin
            state_nxt = S_DATA;
            bcnt_nxt  = BW'(DATA_W - 1);
          end
        end
        S_DATA: begin
          if (cnt == T_MID_P1) shreg_nxt = {shreg[DATA_W-2:0], maj};
          if (cnt == T_END) begin
            if (bcnt == '0) state_nxt = S_STOP;
            else            bcnt_nxt  = bcnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == T_MID_P1) begin
            if (maj) begin
              deliver   = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              ferr      = 1'b1;
              state_nxt = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A delivery coinciding with an accepting handshake reloads the buffer without overrun.
  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= ferr;
      o_overrun   <= 1'b0;
      if (deliver) begin
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          o_data  <= shreg;
          o_valid <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a frame-level expectation model.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       w_intrst;
  logic       i_rxd;
  logic       i_rxpulse = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, stall_viol = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int base_got, base_ferr, base_ovr, t0, nbad;
  logic pre, done, rstop;
  logic [7:0] rb;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .i_clk       (i_clk),
    .w_intrst    (w_intrst),
    .i_rxd       (i_rxd),
    .i_rxpulse   (i_rxpulse),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // One tick every 4 clocks; tick_no names the tick whose edge follows.
  initial begin
    forever begin
      repeat (3) @(negedge i_clk);
      i_rxpulse = 1'b1;
      tick_no++;
      @(negedge i_clk);
      i_rxpulse = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Observer: counts pulses, records accepted bytes, checks held data while stalled.
  initial begin
    logic pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge i_clk);
      #2;
      if (!w_intrst) begin
        if (o_frame_err) ferr_cnt++;
        if (o_overrun) ovr_cnt++;
        if (o_frame_err && o_overrun) both_cnt++;
        if (pv && !pr && (!o_valid || o_data != pd)) stall_viol++;
        if (o_valid && i_ready) got_q.push_back(o_data);
      end
      pv = o_valid && !w_intrst;
      pr = i_ready;
      pd = o_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      while (!i_rxpulse) @(posedge i_clk);
    end
    @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rxd = 1'b0;
    wait_ticks(16);
    for (int i = 7; i >= 0; i--) begin
      i_rxd = b[i];
      wait_ticks(16);
    end
    i_rxd = stop;
    wait_ticks(16);
    i_rxd = 1'b1;
  endtask

  // Start detected on tick t+1; stop-bit tick 9 lands on tick t+155.
  // Returns at the negedge just before that decision edge.
  task automatic at_decision(input int t);
    int n;
    n = 0;
    do begin
      @(posedge i_clk);
      n++;
    end while (!(i_rxpulse && tick_no == t + 154) && n < 3000);
    check("decision_reached", 32'(n < 3000), 1);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    w_intrst = 1'b1;
    i_rxd    = 1'b1;
    i_ready  = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    @(negedge i_clk);
    w_intrst = 1'b0;
    wait_ticks(4);

    // Clean 0xA5: o_valid rises one cycle after the stop decision.
    i_ready = 1'b1;
    base_got = got_q.size(); base_ferr = ferr_cnt;
    t0 = tick_no;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        at_decision(t0);
        pre = o_valid;
        @(negedge i_clk);
        check("a5_valid_before", pre, 0);
        check("a5_valid_after", o_valid, 1);
        check("a5_data", o_data, 8'hA5);
      end
    join
    wait_ticks(4);
    check("a5_count", got_q.size() - base_got, 1);
    check("a5_ferr", ferr_cnt - base_ferr, 0);

    // Four-tick idle glitch is a false start.
    base_got = got_q.size(); base_ferr = ferr_cnt;
    i_rxd = 1'b0;
    wait_ticks(4);
    i_rxd = 1'b1;
    wait_ticks(20);
    check("glitch_count", got_q.size() - base_got, 0);
    check("glitch_ferr", ferr_cnt - base_ferr, 0);
    check("glitch_valid", o_valid, 0);

    // 0x3C with low stop bit, then 0x81 clean.
    base_got = got_q.size(); base_ferr = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(4);
    check("ferr_pulses", ferr_cnt - base_ferr, 1);
    check("ferr_valid", o_valid, 0);
    check("ferr_count", got_q.size() - base_got, 0);
    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    check("after_ferr_count", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) check("after_ferr_data", got_q[base_got], 8'h81);

    // Overrun: 0x11 held, 0x22 dropped.
    i_ready = 1'b0;
    base_got = got_q.size(); base_ovr = ovr_cnt;
    wait_ticks(2);
    send_frame(8'h11, 1'b1);
    wait_ticks(2);
    send_frame(8'h22, 1'b1);
    wait_ticks(4);
    check("ovr_valid", o_valid, 1);
    check("ovr_data_held", o_data, 8'h11);
    check("ovr_pulses", ovr_cnt - base_ovr, 1);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("ovr_drained", o_valid, 0);
    check("ovr_count", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) check("ovr_xfer_data", got_q[base_got], 8'h11);

    // Accept on the exact delivery cycle of the second byte.
    base_got = got_q.size(); base_ovr = ovr_cnt;
    send_frame(8'h33, 1'b1);
    wait_ticks(2);
    t0 = tick_no;
    fork
      send_frame(8'h44, 1'b1);
      begin
        at_decision(t0);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("same_cyc_valid", o_valid, 1);
        check("same_cyc_data", o_data, 8'h44);
      end
    join
    wait_ticks(2);
    check("same_cyc_ovr", ovr_cnt - base_ovr, 0);
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("same_cyc_count", got_q.size() - base_got, 2);
    if (got_q.size() >= base_got + 2) begin
      check("same_cyc_first", got_q[base_got], 8'h33);
      check("same_cyc_second", got_q[base_got+1], 8'h44);
    end

    // Reset during data bit 4 of 0xFF, then 0x5A.
    base_got = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
    i_rxd = 1'b0;
    wait_ticks(16);
    i_rxd = 1'b1;
    wait_ticks(16 * 3 + 8);
    w_intrst = 1'b1;
    @(negedge i_clk);
    #2;
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_ferr", o_frame_err, 0);
    check("midrst_ovr", o_overrun, 0);
    @(negedge i_clk);
    w_intrst = 1'b0;
    wait_ticks(30);
    send_frame(8'h5A, 1'b1);
    wait_ticks(4);
    check("midrst_count", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) check("midrst_byte", got_q[base_got], 8'h5A);
    check("midrst_no_err", (ferr_cnt - base_ferr) + (ovr_cnt - base_ovr), 0);

    // Random frames, glitches, bad stops and random i_ready.
    base_got = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
    nbad = 0;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          rb    = 8'($urandom);
          rstop = ($urandom_range(0, 4) != 0);
          if ($urandom_range(0, 3) == 0) begin
            i_rxd = 1'b0;
            wait_ticks($urandom_range(1, 6));
            i_rxd = 1'b1;
            wait_ticks(12);
          end
          wait_ticks($urandom_range(2, 20));
          send_frame(rb, rstop);
          if (rstop) exp_q.push_back(rb);
          else nbad++;
        end
        wait_ticks(4);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge i_clk);
          i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    check("rand_count", got_q.size() - base_got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_got + i < got_q.size()) check($sformatf("rand_byte%0d", i), got_q[base_got+i], exp_q[i]);
    end
    check("rand_ferr", ferr_cnt - base_ferr, nbad);
    check("rand_ovr", ovr_cnt - base_ovr, 0);

    check("err_ovr_exclusive", both_cnt, 0);
    check("stall_data_stable", stall_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
